// File: rtl/mosaic3c1s_rx_decoder_18x18.sv
// Purpose: 18x18 Mosaic-3C1S receive decoder with BER window statistics; optional pad check via MOSAIC_PAD_CHECK_EN.
// Latency: data_out/data_valid 2 cycles after rx_valid is sampled; counters update one cycle later.
// Backpressure: none; rx_valid only qualifies a word, and bubbles flow through without advancing counts.
module mosaic3c1s_rx_decoder_18x18 #(
    parameter int N_SKIP  = 1,
    parameter int N_WORDS = 10000,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rx_valid,
    input  logic [279:0]     rx_bus,
    input  logic [255:0]     ref_data,
    output logic [255:0]     data_out,
    output logic             data_valid,
    output logic             word_err,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] word_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic             busy,
`ifdef MOSAIC_PAD_CHECK_EN
    output logic             done,
    output logic [CNT_W-1:0] pad_err_cnt
`else
    output logic             done
`endif
);

    typedef enum logic [1:0] {IDLE, SKIP, RUN, DONE} state_t;

    localparam logic [11:0] WEIGHT [12] = '{12'd1, 12'd2, 12'd4, 12'd7, 12'd13, 12'd24,
                                            12'd44, 12'd81, 12'd149, 12'd274, 12'd504, 12'd927};

    function automatic logic [10:0] dec_grp(input logic [11:0] cw);
        logic [11:0] sum;
        sum = '0;
        for (int k = 0; k < 12; k++)
            if (cw[k]) sum = sum + WEIGHT[k];
        return sum[10:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    logic [239:0]     s1_cw;
    logic [35:0]      s1_unc;
    logic [255:0]     s1_ref;
    logic             s1_vld;
    logic [255:0]     dec_word;
    logic [255:0]     s2_mask;
    logic [8:0]       pop;
    logic [CNT_W-1:0] skip_cnt;
    state_t           state, next_state;
    logic             clr;

`ifdef MOSAIC_PAD_CHECK_EN
    logic s1_pad, s2_pad;
`else
    logic unused_pad;
    assign unused_pad = ^{rx_bus[279], rx_bus[242:240]};
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_cw  <= '0;
            s1_unc <= '0;
            s1_ref <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_cw  <= rx_bus[239:0];
            s1_unc <= rx_bus[278:243];
            s1_ref <= ref_data;
            s1_vld <= rx_valid;
        end
    end

    always_comb begin
        dec_word = '0;
        for (int g = 0; g < 20; g++)
            dec_word[11*g +: 11] = dec_grp(s1_cw[12*g +: 12]);
        dec_word[255:220] = s1_unc;
    end

    // data_out and the error mask hold through bubbles; only data_valid drops
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            word_err   <= 1'b0;
            s2_mask    <= '0;
        end else begin
            data_valid <= s1_vld;
            word_err   <= s1_vld && (dec_word != s1_ref);
            if (s1_vld) begin
                data_out <= dec_word;
                s2_mask  <= dec_word ^ s1_ref;
            end
        end
    end

    assign pop = 9'($countones(s2_mask));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        clr        = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                clr        = 1'b1;
                next_state = (N_SKIP == 0) ? RUN : SKIP;
            end
            SKIP: if (data_valid && skip_cnt == CNT_W'(N_SKIP - 1)) next_state = RUN;
            RUN:  if (data_valid && word_cnt == CNT_W'(N_WORDS - 1)) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt     <= '0;
            word_cnt     <= '0;
            word_err_cnt <= '0;
            bit_err_cnt  <= '0;
        end else if (clr) begin
            skip_cnt     <= '0;
            word_cnt     <= '0;
            word_err_cnt <= '0;
            bit_err_cnt  <= '0;
        end else if (data_valid) begin
            if (state == SKIP) skip_cnt <= skip_cnt + 1'b1;
            if (state == RUN) begin
                word_cnt     <= sat_add(word_cnt, CNT_W'(1));
                word_err_cnt <= sat_add(word_err_cnt, CNT_W'(word_err));
                bit_err_cnt  <= sat_add(bit_err_cnt, CNT_W'(pop));
            end
        end
    end

`ifdef MOSAIC_PAD_CHECK_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_pad      <= 1'b0;
            s2_pad      <= 1'b0;
            pad_err_cnt <= '0;
        end else begin
            s1_pad <= (rx_bus[242:240] != 3'b000) || rx_bus[279];
            s2_pad <= s1_pad && s1_vld;
            if (clr)
                pad_err_cnt <= '0;
            else if (state == RUN && data_valid && s2_pad)
                pad_err_cnt <= sat_add(pad_err_cnt, CNT_W'(1));
        end
    end
`endif

    assign busy = (state == SKIP) || (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mosaic3c1s_rx_decoder_18x18.sv
// Directed bench for mosaic3c1s_rx_decoder_18x18 with N_SKIP=1, N_WORDS=4.
module tb_mosaic3c1s_rx_decoder_18x18;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         start;
    logic         rx_valid;
    logic [279:0] rx_bus;
    logic [255:0] ref_data;
    logic [255:0] data_out;
    logic         data_valid;
    logic         word_err;
    logic [31:0]  word_cnt;
    logic [31:0]  word_err_cnt;
    logic [31:0]  bit_err_cnt;
    logic         busy;
    logic         done;
`ifdef MOSAIC_PAD_CHECK_EN
    logic [31:0]  pad_err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [279:0] base_bus;
    logic [255:0] exp_word;
    logic [279:0] bus_v;

    mosaic3c1s_rx_decoder_18x18 #(.N_SKIP(1), .N_WORDS(4), .CNT_W(32)) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_bus       (rx_bus),
        .ref_data     (ref_data),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .word_err     (word_err),
        .word_cnt     (word_cnt),
        .word_err_cnt (word_err_cnt),
        .bit_err_cnt  (bit_err_cnt),
        .busy         (busy),
`ifdef MOSAIC_PAD_CHECK_EN
        .done         (done),
        .pad_err_cnt  (pad_err_cnt)
`else
        .done         (done)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_bus   = '0;
        ref_data = '0;

        base_bus = '0;
        base_bus[11:0]    = 12'h0FF;
        base_bus[239:228] = 12'h800;
        base_bus[278:243] = 36'hA5A5A5A5A;
        base_bus[241]     = 1'b1;
        base_bus[279]     = 1'b1;
        exp_word = '0;
        exp_word[10:0]    = 11'd176;
        exp_word[219:209] = 11'd927;
        exp_word[255:220] = 36'hA5A5A5A5A;

        cyc(); cyc();
        chk("rst_data_out", data_out, 256'd0);
        chk("rst_data_valid", 256'(data_valid), 256'd0);
        chk("rst_word_cnt", 256'(word_cnt), 256'd0);
        chk("rst_busy_done", 256'({busy, done}), 256'd0);
        rst_n = 1'b1;
        cyc();

        // zero word: visible exactly two edges after sampling
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        chk("zero_vld_1cyc", 256'(data_valid), 256'd0);
        cyc();
        chk("zero_vld_2cyc", 256'(data_valid), 256'd1);
        chk("zero_data", data_out, 256'd0);
        chk("zero_word_err", 256'(word_err), 256'd0);
        cyc();
        chk("zero_vld_drop", 256'(data_valid), 256'd0);

        // group weights, uncoded passthrough, pads ignored
        rx_valid = 1'b1; rx_bus = base_bus; ref_data = exp_word;
        cyc();
        rx_valid = 1'b0;
        cyc();
        chk("grp0_176", 256'(data_out[10:0]), 256'd176);
        chk("grp19_927", 256'(data_out[219:209]), 256'd927);
        chk("uncoded", 256'(data_out[255:220]), 256'h0A5A5A5A5A);
        chk("grp_word_err", 256'(word_err), 256'd0);
        cyc();
        chk("hold_data", data_out, exp_word);
        chk("idle_no_count", 256'(word_cnt), 256'd0);

        // window: skip 1, count 4, sixth word ignored
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("win_busy", 256'({busy, done}), 256'b10);
        rx_valid = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        rx_valid = 1'b0;
        chk("win_mid_cnt", 256'(word_cnt), 256'd3);
        for (int i = 0; i < 3; i++) cyc();
        chk("win_done", 256'({busy, done}), 256'b01);
        chk("win_word_cnt", 256'(word_cnt), 256'd4);
        chk("win_werr_cnt", 256'(word_err_cnt), 256'd0);
        chk("win_berr_cnt", 256'(bit_err_cnt), 256'd0);

        // restart from DONE with injected errors
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("rst_clr_cnt", 256'(word_cnt), 256'd0);
        chk("rst_clr_busy", 256'({busy, done}), 256'b10);
        for (int i = 0; i < 5; i++) begin
            bus_v = base_bus;
            if (i == 2) bus_v[243] = ~bus_v[243];
            if (i == 3) bus_v[278:243] = ~bus_v[278:243];
            rx_valid = 1'b1; rx_bus = bus_v;
            cyc();
        end
        rx_valid = 1'b0; rx_bus = base_bus;
        for (int i = 0; i < 3; i++) cyc();
        chk("err_word_cnt", 256'(word_cnt), 256'd4);
        chk("err_werr_cnt", 256'(word_err_cnt), 256'd2);
        chk("err_berr_cnt", 256'(bit_err_cnt), 256'd37);
        chk("err_done", 256'(done), 256'd1);

        // erroneous word in DONE: flag raised, counters frozen
        bus_v = base_bus; bus_v[0] = 1'b0;
        rx_valid = 1'b1; rx_bus = bus_v;
        cyc();
        rx_valid = 1'b0; rx_bus = base_bus;
        cyc();
        chk("done_word_err", 256'(word_err), 256'd1);
        chk("done_grp0", 256'(data_out[10:0]), 256'd175);
        cyc();
        chk("done_frozen", 256'(word_err_cnt), 256'd2);

        // bubbles: 4 valid words among 8 cycles -> 1 skipped, 3 counted
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_valid = (i % 2 == 0);
            cyc();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("bub_word_cnt", 256'(word_cnt), 256'd3);
        chk("bub_busy", 256'({busy, done}), 256'b10);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("run_start_ign", 256'(word_cnt), 256'd3);

        // asynchronous reset mid-RUN
        rx_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_word_cnt", 256'(word_cnt), 256'd0);
        chk("arst_data_out", data_out, 256'd0);
        chk("arst_flags", 256'({data_valid, busy, done}), 256'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("post_rst_cnt", 256'(word_cnt), 256'd0);
        chk("post_rst_idle", 256'({busy, done}), 256'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mosaic3c1s_rx_decoder_18x18.md
Name: mosaic3c1s_rx_decoder_18x18

Overview:
- Receive-side counterpart of the 18x18 Mosaic-3C1S encoder path. Takes the 280-bit bus (240-bit TNS-CAC codeword, 3 pad bits, 36 uncoded bits, 1 pad bit) and decodes the 20 codeword groups back to 220 data bits.
- Reassembles the 256-bit data word.
- Compares each word against a reference word and accumulates word and bit error counts over a measurement window, giving BER figures for simulation and post-layout ADE runs.

Parameters:
- N_SKIP, 1, valid words discarded after start before counting begins (0 allowed).
- N_WORDS, 10000, valid words counted in the window (must be >= 1).
- CNT_W, 32, width of all statistics counters.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; starts or restarts a measurement.
- rx_valid  input  1  rx_bus/ref_data hold a word this cycle.
- rx_bus  input  280  received bus: [239:0] codeword, [242:240] pad, [278:243] uncoded, [279] pad.
- ref_data  input  256  transmitted data word, aligned with rx_bus.
- data_out  output  256  decoded word.
- data_valid  output  1  data_out valid.
- word_err  output  1  data_out differs from the aligned ref_data; qualified by data_valid.
- word_cnt  output  CNT_W  words counted in window.
- word_err_cnt  output  CNT_W  erroneous words counted.
- bit_err_cnt  output  CNT_W  erroneous bits counted.
- busy  output  1  FSM in SKIP or RUN.
- done  output  1  FSM in DONE.

Behaviour:
- Reset: all outputs, pipeline registers and counters are 0; FSM is in IDLE.
- Stage 1 (edge n): register rx_bus, ref_data and rx_valid.
- Stage 2 (edge n+1): decode the codeword.
  - Group g (0..19) is codeword bits [12g+11:12g].
  - Decoded value = sum of W_k over set bits k, truncated to 11 bits.
  - Weights: W0=1, W1=2, W2=4, Wk=W(k-1)+W(k-2)+W(k-3), giving 1,2,4,7,13,24,44,81,149,274,504,927.
  - Group result goes to data bits [11g+10:11g].
  - data_out[255:220] = rx_bus[278:243].
  - Pad bits are ignored.
- data_out, data_valid and word_err are registered at this stage. data_out/data_valid appear 2 cycles after rx_valid is sampled.
  - data_out holds its last value when data_valid=0.
  - word_err is computed against the stage-1 copy of ref_data.
- Stage 3 (edge n+2): XOR mask popcount (0..256), consumed by the counters. Counters update on the edge after data_valid is high.
- FSM states: IDLE, SKIP, RUN, DONE.
  - IDLE: start -> clear counters; go to SKIP (RUN if N_SKIP=0).
  - SKIP: count stage-3 valid words. After the N_SKIP-th word -> RUN; that word is not counted.
  - RUN: per stage-3 valid word:
    - word_cnt += 1
    - word_err_cnt += word error flag
    - bit_err_cnt += popcount
    - The update that makes word_cnt reach N_WORDS moves the FSM to DONE.
  - DONE: counters frozen. start -> clear counters, go to SKIP/RUN as from IDLE.
- start in SKIP or RUN is ignored.
- Words in flight in the pipeline when start arrives count toward SKIP.
- Counters saturate at all-ones; they never wrap.
- rx_valid=0 bubbles propagate and do not advance any count.
- rst_n asserted mid-measurement: immediate return to reset state; pipeline contents discarded.

Optional Feature:
- MOSAIC_PAD_CHECK_EN defined:
  - Extra output port pad_err_cnt (CNT_W).
  - In RUN, it increments once per valid word whose rx_bus[242:240] or rx_bus[279] is nonzero.
  - It saturates, clears on start, and is 0 at reset.
- Not defined: the port and logic are absent; pad bits are fully ignored.

Test Plan:
- Zero word: rx_bus=0, ref_data=0, one valid cycle -> data_out=0, word_err=0, exactly 2 cycles later.
- Group weights:
  - group0=12'h0FF, group19=12'h800, rest 0 -> data_out[10:0]=176, data_out[219:209]=927.
  - Uncoded bits rx_bus[278:243]=36'hA5A5A5A5A -> data_out[255:220]=36'hA5A5A5A5A.
- Window: N_SKIP=1, N_WORDS=4, start then 6 matching words -> done after the 5th word. Final counts: word_cnt=4, word_err_cnt=0, bit_err_cnt=0; the 6th word is ignored.
- Errors: in RUN, flip rx_bus[243] in word 2 and invert all 36 uncoded bits in word 3 -> word_err_cnt=2, bit_err_cnt=37.
- Bubbles/restart: rx_valid toggles every cycle -> word_cnt advances only on valid words. start in DONE -> counters clear to 0 and busy=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 for one cycle with word_cnt=3 -> all outputs 0 asynchronously; FSM in IDLE; no counting until the next start.
